// File: rtl/risac_lsu_pkg.sv
// risac_lsu_pkg
//   Shared definitions for the risac load/store Avalon-MM master:
//   access-size encodings, the FSM state type and the alignment check.
package risac_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_t;

  // An access is rejected when it does not fit its natural alignment,
  // or when the size code is the reserved one.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == SZ_ILL)                           bad = 1'b1;
    else if (size == SZ_HALF && addr_lo[0])       bad = 1'b1;
    else if (size == SZ_WORD && addr_lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/risac_lsu_avalon_master_if.sv
// risac_lsu_avalon_master_if
//   Bundles the core request/response handshake and the Avalon-MM
//   master signals of the LSU.
//   modport master : the LSU block (drives req_ready, rsp_*, avm_* commands)
//   modport slave  : the environment (core + interconnect/memory)
interface risac_lsu_avalon_master_if #(
  parameter int ADDR_W = 15
);
  // core side
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  // Avalon-MM side
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/risac_lsu_lane_align.sv
// risac_lsu_lane_align
//   Combinational byte-lane steering for a 32-bit uncached master.
//   Write side: wr_size/wr_addr_lo/wr_data -> wr_be, wr_data_rep
//               (store data replicated into every lane of its size).
//   Read side : rd_size/rd_addr_lo/rd_unsigned/rd_data -> rd_data_ext
//               (lane shifted down to bit 0, then sign/zero extended).
module risac_lsu_lane_align
  import risac_lsu_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [1:0]  wr_addr_lo,
  input  logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_data_rep,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_addr_lo,
  input  logic        rd_unsigned,
  input  logic [31:0] rd_data,
  output logic [31:0] rd_data_ext
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
    logic signed [7:0]  sb;
    logic signed [31:0] sw;
    sb = b;
    sw = sb;
    return uns ? {24'd0, b} : sw;
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    sh = h;
    sw = sh;
    return uns ? {16'd0, h} : sw;
  endfunction

  logic [31:0] rd_shifted;

  always_comb begin
    wr_be       = 4'b1111;
    wr_data_rep = wr_data;
    case (wr_size)
      SZ_BYTE: begin
        wr_be       = 4'b0001 << wr_addr_lo;
        wr_data_rep = {4{wr_data[7:0]}};
      end
      SZ_HALF: begin
        wr_be       = wr_addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_data_rep = {2{wr_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_shifted  = rd_data >> {rd_addr_lo, 3'b000};
    rd_data_ext = rd_shifted;
    case (rd_size)
      SZ_BYTE: rd_data_ext = ext_byte(rd_shifted[7:0], rd_unsigned);
      SZ_HALF: rd_data_ext = ext_half(rd_shifted[15:0], rd_unsigned);
      default: ;
    endcase
  end

endmodule

// File: rtl/risac_lsu_avalon_master.sv
// risac_lsu_avalon_master
//   Converts core load/store requests into single Avalon-MM transfers,
//   one outstanding at a time. Misaligned/illegal requests are answered
//   with an error response without touching the bus.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : core handshake + Avalon-MM master signals (master modport)
module risac_lsu_avalon_master
  import risac_lsu_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  risac_lsu_avalon_master_if.master     bus
);

  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  lsu_state_t  state_q, state_d;
  logic [2:0]  cnt_q;
  logic [1:0]  size_p0;
  logic [1:0]  alo_p0;
  logic        uns_p0;
  logic        we_p0;

  logic        accept, acc_err, cmd_done, rd_done;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rdata_c;

  risac_lsu_lane_align u_align (
    .wr_size     (bus.req_size),
    .wr_addr_lo  (bus.req_addr[1:0]),
    .wr_data     (bus.req_wdata),
    .wr_be       (be_c),
    .wr_data_rep (wdata_c),
    .rd_size     (size_p0),
    .rd_addr_lo  (alo_p0),
    .rd_unsigned (uns_p0),
    .rd_data     (bus.avm_readdata),
    .rd_data_ext (rdata_c)
  );

  assign bus.req_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    acc_err  = 1'b0;
    cmd_done = 1'b0;
    rd_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (misaligned(bus.req_size, bus.req_addr[1:0])) acc_err = 1'b1;
          else                                             state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (!bus.avm_waitrequest) begin
          cmd_done = 1'b1;
          state_d  = we_p0 ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          rd_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= ST_IDLE;
      cnt_q              <= 3'd0;
      size_p0            <= SZ_BYTE;
      alo_p0             <= 2'd0;
      uns_p0             <= 1'b0;
      we_p0              <= 1'b0;
      bus.avm_address    <= '0;
      bus.avm_byteenable <= 4'd0;
      bus.avm_writedata  <= 32'd0;
      bus.avm_read       <= 1'b0;
      bus.avm_write      <= 1'b0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_err        <= 1'b0;
      bus.rsp_rdata      <= 32'd0;
    end else begin
      state_q <= state_d;

      // request capture -> command stage
      if (accept && !acc_err) begin
        bus.avm_address    <= bus.req_addr[ADDR_W+1:2];
        bus.avm_byteenable <= be_c;
        bus.avm_writedata  <= wdata_c;
        bus.avm_read       <= !bus.req_we;
        bus.avm_write      <= bus.req_we;
        size_p0            <= bus.req_size;
        alo_p0             <= bus.req_addr[1:0];
        uns_p0             <= bus.req_unsigned;
        we_p0              <= bus.req_we;
      end else if (cmd_done) begin
        bus.avm_read  <= 1'b0;
        bus.avm_write <= 1'b0;
      end

      // command accepted -> read latency countdown
      if (cmd_done && !we_p0)                 cnt_q <= CNT_INIT;
      else if (state_q == ST_WAIT && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;

      // response stage
      bus.rsp_valid <= acc_err | (cmd_done & we_p0) | rd_done;
      bus.rsp_err   <= acc_err;
      bus.rsp_rdata <= rd_done ? rdata_c : 32'd0;
    end
  end

endmodule

// File: doc/risac_lsu_avalon_master.md
# risac_lsu_avalon_master

Avalon-MM master that turns the core's load/store request/response handshake into single Avalon-MM transfers toward the on-chip memory slave. It handles:
- byte-lane steering on writes;
- `waitrequest` stalls;
- fixed pipelined read latency;
- sign/zero extension on reads;
- misalignment detection.

One transaction is outstanding at a time. It sits between the risac load/store unit and the system interconnect.

## Interface
Parameters:
- `ADDR_W`, 15, word-address width of `avm_address` (matches a 32768-word memory).
- `READ_LATENCY`, 1, cycles from read command acceptance to valid `avm_readdata`; legal range 1..7.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned` in 1: zero-extend load (byte/half).
- `req_wdata` in 32: store data, LSB-aligned.
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_rdata` out 32: extended load data; 0 for stores/errors.
- `rsp_err` out 1: misaligned or illegal size; no bus access made.
- `avm_address` out ADDR_W: word address = `req_addr[ADDR_W+1:2]`.
- `avm_byteenable` out 4: lane enables.
- `avm_read` out 1: read command.
- `avm_write` out 1: write command.
- `avm_writedata` out 32: lane-replicated store data.
- `avm_readdata` in 32: slave read data.
- `avm_waitrequest` in 1: slave stall; tie 0 for the on-chip memory.

## Operation
States: IDLE, BUS, WAIT.

- **IDLE.** `req_ready` = 1. On `req_valid`, the request is accepted.
  - **Error check.** An error is flagged on any of: half with `addr[0]` = 1, word with `addr[1:0]` ≠ 0, or size 3.
  - **Error path.** The next cycle has `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0. State stays IDLE.
  - **Otherwise.** The block registers address, byteenable, writedata, size, unsigned and `addr[1:0]`, then moves to BUS.
- **BUS.** Drives `avm_read` or `avm_write` = 1 (never both). Registered command signals are held stable while `avm_waitrequest` = 1. With `avm_waitrequest` = 0 the command is accepted:
  - write → IDLE with `rsp_valid` = 1 next cycle;
  - read → WAIT, with the counter loaded to `READ_LATENCY-1`.
- **WAIT.** Command outputs are deasserted. The counter decrements each cycle. At count 0:
  - `avm_readdata` is captured and extended;
  - the state returns to IDLE;
  - `rsp_valid` pulses the next cycle.
- **Byteenable / write data.**
  - byte: `be = 1<<addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - half: `be = addr[1] ? 1100 : 0011`, `wdata = {2{wdata[15:0]}}`.
  - word: `be = 1111`, `wdata = wdata`.
- **Read extract.** Shift `avm_readdata` right by `8*addr[1:0]`, then:
  - byte: bits [7:0], extended (sign or zero per `req_unsigned`);
  - half: bits [15:0], extended;
  - word: unchanged.
- **Reset.** `reset_n` low at any time, including mid-transaction, gives:
  - IDLE state;
  - `avm_read`, `avm_write`, `rsp_valid`, `rsp_err` = 0;
  - `avm_address`, `avm_byteenable`, `avm_writedata`, `rsp_rdata` = 0;
  - `req_ready` = 1 once `reset_n` is high.

  An in-flight transaction is dropped without a response.
- **Request handling outside IDLE.** `req_valid` outside IDLE is ignored, because `req_ready` = 0.

## Timing
Request accepted in cycle A. Each response is a single-cycle `rsp_valid` pulse.
- **Error:** `rsp_valid` at A+1. The next request can be accepted at A+1.
- **Write, no stall:** `avm_write` at A+1, `rsp_valid` at A+2, `req_ready` at A+2. Each stall cycle adds one cycle.
- **Read, no stall:** command accepted at T = A+1, data sampled at T+`READ_LATENCY`, `rsp_valid` at T+`READ_LATENCY`+1. For `READ_LATENCY` = 1 that is A+3.
- **Back-to-back requests:** minimum spacing is 2 cycles for writes and `READ_LATENCY`+2 for reads.
- **Registered outputs:** all outputs except `req_ready` are registered. `req_ready` is decoded from state only and never depends on `req_valid`.

## Structure
- **Package `risac_lsu_pkg`:**
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - state enum `lsu_state_t` (IDLE/BUS/WAIT);
  - function `misaligned(size, addr_lo)`.
- **Sub-module `risac_lsu_lane_align`:** combinational; produces byteenable, replicated wdata, and read shift/extend. It is reused by any future uncached master.
- **Top level:** contains the FSM, latency counter and registers.

## Test plan
1. **Word store.** `sb`-free word store: addr 0x10, wdata 0xDEADBEEF, waitrequest 0.
   - A+1: `avm_address` = 4, be = 1111, `avm_write` = 1.
   - A+2: `rsp_valid` = 1, `rsp_err` = 0.
2. **Signed byte load.** addr 0x13, `avm_readdata` = 0x80FF_0000, `READ_LATENCY` = 1.
   - be = 1000.
   - `rsp_rdata` = 0xFFFF_FF80 at A+3.
   - With `req_unsigned` = 1: 0x0000_0080.
3. **Half store.** addr 0x06, wdata 0x0000_1234.
   - be = 1100, writedata = 0x1234_1234.
4. **Misaligned word load.** addr 0x02.
   - No `avm_read` ever.
   - A+1: `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0.
   - Same behaviour for size 3.
5. **Waitrequest stall.** `avm_waitrequest` high 3 cycles on a read.
   - Address/byteenable/read held stable for 4 cycles.
   - `rsp_valid` exactly `READ_LATENCY`+1 cycles after waitrequest drops.
   - Repeat with `READ_LATENCY` = 3.
6. **Reset in WAIT.** Assert `reset_n` = 0 in WAIT.
   - All outputs 0 asynchronously.
   - No `rsp_valid` after release.
   - A new request after release completes normally.
